pio_in_edge_capture: RTL and testbench
======================================

Name: pio_in_edge_capture

Overview:
- Parametrised successor to the single-bit status input port on the processor's Avalon-MM bus: a DATA_WIDTH-bit input port that reads back status lines from the signal-processing datapath (e.g. calculation-done flags).
- Adds an input synchroniser, per-bit edge capture with write-1-to-clear, a per-bit interrupt mask, an irq output and a saturating event counter.
- Sits between the processing blocks and the Nios-side Avalon interconnect.

Parameters:
- DATA_WIDTH, 1, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (2..4).
- EDGE_TYPE, 0, which edge is captured: 0 = rising, 1 = falling, 2 = any.
- RESET_MASK, 0, reset value of the irq mask register (DATA_WIDTH bits).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  Avalon write data; bits at or above DATA_WIDTH are ignored.
- in_port  in  DATA_WIDTH  asynchronous status inputs.
- readdata  out  32  registered read data; bits at or above DATA_WIDTH are zero for registers 0–2.
- irq  out  1  level interrupt, high while any captured and unmasked bit is set.

Behaviour:
- Reset: when reset_n=0 at a clk edge, every flop is cleared. This covers the synchroniser chain, the previous-sample register, edge_capture, the event counter, readdata and the warm-up counter. irq_mask is loaded with RESET_MASK. irq=0 from the following cycle. Reset mid-operation discards all pending captures.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync. prev holds sync delayed by one cycle.
- Edge detection per bit:
  - rising = sync & ~prev
  - falling = ~sync & prev
  - any = sync ^ prev
  - EDGE_TYPE selects one of these as edge.
- Warm-up: edge is forced to 0 for the first SYNC_STAGES+1 cycles after reset deasserts, tracked by a small counter that saturates once done. An input held high through reset therefore produces no spurious capture.
- Register map (address):
  - 0 DATA: read returns sync. Writes are ignored.
  - 1 IRQ_MASK: read/write; irq_mask <= writedata[DATA_WIDTH-1:0].
  - 2 EDGE_CAPTURE: read returns edge_capture. A write clears each bit whose writedata bit is 1.
  - 3 EVENT_COUNT: read returns the 32-bit counter. Any write clears it.
- Edge capture update per bit: next = (cur & ~clr) | edge, where clr is the write-1-to-clear mask (0 when not writing address 2). If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Event counter:
  - Increments by 1 in each cycle where |edge = 1, regardless of irq_mask.
  - Saturates at 32'hFFFF_FFFF with no wrap.
  - A write to address 3 in the same cycle as an event loads 1; without an event it loads 0.
- readdata: updated every cycle from the register selected by address, regardless of chipselect or read. Read latency is 1 cycle. It reflects register values before any write in that same cycle.
- irq: combinational OR of (edge_capture & irq_mask), driven only from flops (glitch-free). It deasserts the cycle after the clearing write or mask write takes effect.
- Latency: an in_port change reaches DATA readback after SYNC_STAGES+1 cycles. It reaches edge_capture, irq and the counter after SYNC_STAGES+1 cycles, with readback one cycle later.

Test Plan:
- Reset with in_port=8'hFF held (DATA_WIDTH=8, EDGE_TYPE=0) -> after release, DATA reads 8'hFF, EDGE_CAPTURE reads 0, EVENT_COUNT reads 0, irq=0.
- in_port bit 3 pulses 0→1 for 1 cycle, mask=8'h08 -> EDGE_CAPTURE=8'h08 and irq=1 after SYNC_STAGES+1 cycles, EVENT_COUNT=1. Write 8'h08 to address 2 -> capture=0, irq=0 next cycle.
- New rising edge on bit 3 in the same cycle as a write-1-to-clear of bit 3 -> bit 3 remains 1, irq stays 1.
- EDGE_TYPE=2, bit 0 toggled 5 times with spaced transitions -> EVENT_COUNT=5. Mask=0 -> irq never asserts, while EDGE_CAPTURE=1.
- Preload the counter near its limit by forcing it to 32'hFFFF_FFFE, then apply 3 edges -> EVENT_COUNT=32'hFFFF_FFFF. Write address 3 during an edge -> EVENT_COUNT=1.
- Assert reset_n=0 for 1 cycle while captures are pending and irq=1 -> all registers 0, irq_mask=RESET_MASK, irq=0, no capture during warm-up.

Source files
------------

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM status input port: input synchroniser, per-bit edge capture with
// write-1-to-clear, irq mask, level irq and a saturating event counter.
module pio_in_edge_capture #(
   parameter int unsigned           DATA_WIDTH  = 1,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter int unsigned           EDGE_TYPE   = 0,
   parameter logic [DATA_WIDTH-1:0] RESET_MASK  = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
   localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);
   localparam logic [1:0]  ADDR_DATA   = 2'd0;
   localparam logic [1:0]  ADDR_MASK   = 2'd1;
   localparam logic [1:0]  ADDR_EDGE   = 2'd2;
   localparam logic [1:0]  ADDR_COUNT  = 2'd3;
   localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;

   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] cap_q,  cap_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [31:0]           cnt_q,  cnt_d;
   logic [31:0]           rd_q,   rd_d;
   logic [WARM_W-1:0]     warm_q, warm_d;

   logic [DATA_WIDTH-1:0] sync;
   logic [DATA_WIDTH-1:0] edge_raw;
   logic [DATA_WIDTH-1:0] edge_det;
   logic [DATA_WIDTH-1:0] clr;
   logic                  warm_done;
   logic                  wr_en;
   logic                  evt;
   logic                  unused_wdata;

   assign sync         = sync_q[SYNC_STAGES-1];
   assign wr_en        = chipselect & ~write_n;
   assign warm_done    = (warm_q == WARM_W'(WARM_CYCLES));
   assign unused_wdata = ^writedata;

   // Edge selection; suppressed until the synchroniser and prev hold real samples
   always_comb begin
      edge_raw = sync ^ prev_q;
      case (EDGE_TYPE)
         0:       edge_raw = sync & ~prev_q;
         1:       edge_raw = ~sync & prev_q;
         default: edge_raw = sync ^ prev_q;
      endcase
      edge_det = warm_done ? edge_raw : '0;
   end

   assign evt = |edge_det;

   // Register next-state; a same-cycle set beats the write-1-to-clear
   always_comb begin
      warm_d = warm_done ? warm_q : warm_q + WARM_W'(1);
      clr    = '0;
      mask_d = mask_q;
      cnt_d  = cnt_q;
      if (wr_en && address == ADDR_EDGE) begin
         clr = writedata[DATA_WIDTH-1:0];
      end
      if (wr_en && address == ADDR_MASK) begin
         mask_d = writedata[DATA_WIDTH-1:0];
      end
      cap_d = (cap_q & ~clr) | edge_det;
      if (wr_en && address == ADDR_COUNT) begin
         cnt_d = evt ? 32'd1 : 32'd0;
      end else if (evt && cnt_q != COUNT_MAX) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Read mux samples pre-write register values every cycle
   always_comb begin
      rd_d = '0;
      case (address)
         ADDR_DATA:  rd_d = 32'(sync);
         ADDR_MASK:  rd_d = 32'(mask_q);
         ADDR_EDGE:  rd_d = 32'(cap_q);
         ADDR_COUNT: rd_d = cnt_q;
         default:    rd_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= '0;
         cap_q  <= '0;
         mask_q <= RESET_MASK;
         cnt_q  <= '0;
         rd_q   <= '0;
         warm_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
         prev_q <= sync;
         cap_q  <= cap_d;
         mask_q <= mask_d;
         cnt_q  <= cnt_d;
         rd_q   <= rd_d;
         warm_q <= warm_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Scoreboard bench for pio_in_edge_capture: a rising-edge and an any-edge
// instance share the Avalon bus; reads push expectations, a monitor checks them.
module tb_pio_in_edge_capture;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_r;
   logic [7:0]  in_a;
   logic [31:0] rd_r, rd_a;
   logic        irq_r, irq_a;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      bit          sel;
      logic [31:0] rd;
      logic        irq;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pio_in_edge_capture #(
      .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_MASK(8'h5A)
   ) dut_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_r),
      .readdata(rd_r), .irq(irq_r)
   );

   pio_in_edge_capture #(
      .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_MASK(8'h00)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a),
      .readdata(rd_a), .irq(irq_a)
   );

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   // sel 0 = rising instance, 1 = any-edge instance; irq checked one cycle after issue
   task automatic rd(input logic [1:0] a, input bit sel, input logic [31:0] exp_rd,
                     input logic exp_irq, input string name);
      exp_t e;
      e.name = name; e.sel = sel; e.rd = exp_rd; e.irq = exp_irq;
      sb.push_back(e);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
   endtask

   task automatic pulse_r(input int b);
      in_r[b] = 1'b1;
      idle(1);
      in_r[b] = 1'b0;
   endtask

   initial begin : monitor
      exp_t        e;
      logic        issued;
      logic [31:0] got_rd;
      logic        got_irq;
      forever begin
         @(posedge clk);
         issued = chipselect && write_n;
         @(negedge clk);
         if (issued) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_read: no expectation queued");
            end else begin
               e       = sb.pop_front();
               got_rd  = e.sel ? rd_a : rd_r;
               got_irq = e.sel ? irq_a : irq_r;
               checks++;
               if (got_rd !== e.rd) begin
                  failures++;
                  $display("FAIL %s readdata: got %h expected %h", e.name, got_rd, e.rd);
               end
               checks++;
               if (got_irq !== e.irq) begin
                  failures++;
                  $display("FAIL %s irq: got %b expected %b", e.name, got_irq, e.irq);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_r = 8'hFF; in_a = 8'h00;
      idle(3);
      reset_n = 1'b1;
      idle(5);

      // Input held high through reset: no spurious capture
      rd(2'd0, 1'b0, 32'h0000_00FF, 1'b0, "rst_data");
      rd(2'd2, 1'b0, 32'h0000_0000, 1'b0, "rst_cap");
      rd(2'd3, 1'b0, 32'h0000_0000, 1'b0, "rst_cnt");
      rd(2'd1, 1'b0, 32'h0000_005A, 1'b0, "rst_mask_r");
      rd(2'd1, 1'b1, 32'h0000_0000, 1'b0, "rst_mask_a");

      // Single-cycle pulse on bit 3, then W1C
      in_r = 8'h00;
      idle(5);
      wr(2'd1, 32'h0000_0008);
      rd(2'd1, 1'b0, 32'h0000_0008, 1'b0, "mask_wr");
      pulse_r(3);
      idle(3);
      rd(2'd2, 1'b0, 32'h0000_0008, 1'b1, "pulse_cap");
      rd(2'd3, 1'b0, 32'h0000_0001, 1'b1, "pulse_cnt");
      rd(2'd0, 1'b0, 32'h0000_0000, 1'b1, "pulse_data");
      wr(2'd2, 32'h0000_0008);
      rd(2'd2, 1'b0, 32'h0000_0000, 1'b0, "w1c_clear");

      // Set and clear of bit 3 in the same cycle: set wins
      pulse_r(3);
      idle(3);
      rd(2'd2, 1'b0, 32'h0000_0008, 1'b1, "pre_collide");
      pulse_r(3);
      idle(1);
      wr(2'd2, 32'h0000_0008);
      rd(2'd2, 1'b0, 32'h0000_0008, 1'b1, "collide_set_wins");
      rd(2'd3, 1'b0, 32'h0000_0003, 1'b1, "collide_cnt");
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2, 1'b0, 32'h0000_0000, 1'b0, "clear_all");

      // Any-edge instance, mask 0: five transitions counted, irq stays low
      wr(2'd1, 32'h0000_0000);
      for (int i = 0; i < 5; i++) begin
         in_a[0] = ~in_a[0];
         idle(4);
         rd(2'd0, 1'b1, 32'(in_a), 1'b0, $sformatf("any_toggle%0d", i));
      end
      rd(2'd3, 1'b1, 32'h0000_0005, 1'b0, "any_cnt5");
      rd(2'd2, 1'b1, 32'h0000_0001, 1'b0, "any_cap_masked");

      // Counter saturation and write-during-event
      force dut_a.cnt_q = 32'hFFFF_FFFE;
      idle(2);
      release dut_a.cnt_q;
      rd(2'd3, 1'b1, 32'hFFFF_FFFE, 1'b0, "cnt_preload");
      for (int i = 0; i < 3; i++) begin
         in_a[0] = ~in_a[0];
         idle(4);
      end
      rd(2'd3, 1'b1, 32'hFFFF_FFFF, 1'b0, "cnt_saturate");
      in_a[0] = ~in_a[0];
      idle(2);
      wr(2'd3, 32'h0000_0000);
      rd(2'd3, 1'b1, 32'h0000_0001, 1'b0, "cnt_wr_with_event");
      wr(2'd3, 32'h0000_0000);
      rd(2'd3, 1'b1, 32'h0000_0000, 1'b0, "cnt_wr_no_event");

      // Mid-operation reset with a pending capture and irq high
      wr(2'd1, 32'h0000_0008);
      pulse_r(3);
      idle(3);
      rd(2'd2, 1'b0, 32'h0000_0008, 1'b1, "pre_reset_cap");
      reset_n = 1'b0;
      in_r    = 8'hFF;
      idle(1);
      reset_n = 1'b1;
      rd(2'd2, 1'b0, 32'h0000_0000, 1'b0, "post_reset_irq");
      idle(5);
      rd(2'd2, 1'b0, 32'h0000_0000, 1'b0, "warmup_no_cap");
      rd(2'd3, 1'b0, 32'h0000_0000, 1'b0, "post_reset_cnt");
      rd(2'd1, 1'b0, 32'h0000_005A, 1'b0, "post_reset_mask");
      rd(2'd0, 1'b0, 32'h0000_00FF, 1'b0, "post_reset_data");

      idle(3);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
